// File: rtl/turn_signal_ctrl.sv
// Turn-signal / hazard / brake lamp controller: synchronizes switch inputs, runs a blink FSM.
// Optional input debounce stage enabled by defining CAR_LIGHT_DEBOUNCE_EN.
module turn_signal_ctrl #(
  parameter int HALF_PERIOD     = 500000,
  parameter int MIN_FLASHES     = 3,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] car_status,
  output logic       en_l,
  output logic       en_r,
  output logic [2:0] mode
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEFT   = 3'd1,
    RIGHT  = 3'd2,
    HAZARD = 3'd3
  } state_e;

  localparam int PW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int FW = (MIN_FLASHES > 0) ? $clog2(MIN_FLASHES + 1) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(HALF_PERIOD - 1);
  localparam logic [FW-1:0] FLASH_MIN  = FW'(MIN_FLASHES);

  if (HALF_PERIOD < 2 || MIN_FLASHES < 1 || DEBOUNCE_CYCLES < 1) begin : g_bad_params
    $error("turn_signal_ctrl: HALF_PERIOD>=2, MIN_FLASHES>=1, DEBOUNCE_CYCLES>=1 required");
  end

  logic [3:0] sync1_q, sync2_q;
  logic [3:0] status;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= car_status;
      sync2_q <= sync1_q;
    end
  end

`ifdef CAR_LIGHT_DEBOUNCE_EN
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]    deb_q;
  logic [DW-1:0] deb_cnt_q [4];

  // A bit flips only after DEBOUNCE_CYCLES consecutive samples disagree with the accepted value.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_q <= '0;
      for (int i = 0; i < 4; i++) deb_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          deb_cnt_q[i] <= '0;
        end else if (deb_cnt_q[i] == DEB_LAST) begin
          deb_q[i]     <= sync2_q[i];
          deb_cnt_q[i] <= '0;
        end else begin
          deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign status = deb_q;
`else
  assign status = sync2_q;
`endif

  logic req_hazard, req_left, req_right, brake;
  assign req_hazard = status[2] | (status[0] & status[1]);
  assign req_left   = status[0] & ~req_hazard;
  assign req_right  = status[1] & ~req_hazard;
  assign brake      = status[3];

  state_e        state_q, state_d;
  logic          phase_q, phase_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [FW-1:0] flash_q, flash_d;
  logic          en_l_q, en_l_d, en_r_q, en_r_d;

  logic          phase_wrap, off_end, min_met;
  logic [FW-1:0] flash_next;

  // NOTE: every always_comb target gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    pcnt_d     = pcnt_q;
    flash_d    = flash_q;
    phase_wrap = (pcnt_q == PHASE_LAST);
    off_end    = phase_wrap & ~phase_q;
    flash_next = (off_end && flash_q != FLASH_MIN) ? flash_q + 1'b1 : flash_q;
    min_met    = (flash_next == FLASH_MIN);

    if (state_q != IDLE) begin
      pcnt_d  = phase_wrap ? '0 : pcnt_q + 1'b1;
      phase_d = phase_wrap ? ~phase_q : phase_q;
      flash_d = flash_next;
    end

    unique case (state_q)
      IDLE: begin
        if (req_hazard)     state_d = HAZARD;
        else if (req_left)  state_d = LEFT;
        else if (req_right) state_d = RIGHT;
      end
      LEFT: begin
        if (req_hazard) state_d = HAZARD;
        else if (off_end && min_met) begin
          if (req_right)     state_d = RIGHT;
          else if (!req_left) state_d = IDLE;
        end
      end
      RIGHT: begin
        if (req_hazard) state_d = HAZARD;
        else if (off_end && min_met) begin
          if (req_left)        state_d = LEFT;
          else if (!req_right) state_d = IDLE;
        end
      end
      HAZARD: begin
        if (!req_hazard && off_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Any state change restarts the blink: ON for an active state, OFF when idling.
    if (state_d != state_q) begin
      phase_d = (state_d != IDLE);
      pcnt_d  = '0;
      flash_d = '0;
    end

    en_l_d = (state_d == LEFT  || state_d == HAZARD) ? phase_d : brake;
    en_r_d = (state_d == RIGHT || state_d == HAZARD) ? phase_d : brake;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= 1'b0;
      pcnt_q  <= '0;
      flash_q <= '0;
      en_l_q  <= 1'b0;
      en_r_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      pcnt_q  <= pcnt_d;
      flash_q <= flash_d;
      en_l_q  <= en_l_d;
      en_r_q  <= en_r_d;
    end
  end

  assign en_l = en_l_q;
  assign en_r = en_r_q;
  assign mode = state_q;

endmodule

// File: tb/tb_turn_signal_ctrl.sv
// Directed scoreboard bench for turn_signal_ctrl with HALF_PERIOD=4, MIN_FLASHES=2, no debounce.
module tb_turn_signal_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] car_status;
  logic       en_l, en_r;
  logic [2:0] mode;

  always #5 clk = ~clk;

  turn_signal_ctrl #(
    .HALF_PERIOD    (4),
    .MIN_FLASHES    (2),
    .DEBOUNCE_CYCLES(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .car_status(car_status),
    .en_l      (en_l),
    .en_r      (en_r),
    .mode      (mode)
  );

  typedef struct {
    logic [4:0] val;  // {en_l, en_r, mode}
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   cycle  = 0;

  task automatic expect_n(input logic l, input logic r, input logic [2:0] m,
                          input int n, input string tag);
    exp_t e;
    e.val = {l, r, m};
    e.tag = tag;
    repeat (n) sb.push_back(e);
  endtask

  // One clock per iteration; outputs sampled 1 time unit after the edge.
  task automatic tick(input int n);
    exp_t e;
    repeat (n) begin
      @(posedge clk);
      #1;
      cycle++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        assert ({en_l, en_r, mode} === e.val) passes++;
        else $error("FAIL %s @cycle %0d: observed {en_l,en_r,mode}=%b expected %b",
                    e.tag, cycle, {en_l, en_r, mode}, e.val);
      end
    end
  endtask

  task automatic reset_pulse(input int n);
    rst        = 1'b1;
    car_status = 4'b0000;
    expect_n(0, 0, 3'd0, n, "reset");
    tick(n);
    rst = 1'b0;
  endtask

  initial begin
    // Left held through reset: en_l rises 3 cycles after release, blinks 4/4, keeps going while held.
    rst        = 1'b1;
    car_status = 4'b0001;
    expect_n(0, 0, 3'd0, 2, "reset_state");
    tick(2);
    rst = 1'b0;
    expect_n(0, 0, 3'd0, 2, "left_latency");
    expect_n(1, 0, 3'd1, 4, "left_on1");
    expect_n(0, 0, 3'd1, 4, "left_off1");
    expect_n(1, 0, 3'd1, 4, "left_on2");
    expect_n(0, 0, 3'd1, 4, "left_off2");
    expect_n(1, 0, 3'd1, 4, "left_held_on3");
    tick(22);

    // Reset mid-blink, then a one-cycle left pulse gives exactly two flashes.
    reset_pulse(1);
    car_status = 4'b0001;
    expect_n(0, 0, 3'd0, 2, "pulse_latency");
    expect_n(1, 0, 3'd1, 4, "pulse_on1");
    expect_n(0, 0, 3'd1, 4, "pulse_off1");
    expect_n(1, 0, 3'd1, 4, "pulse_on2");
    expect_n(0, 0, 3'd1, 4, "pulse_off2");
    expect_n(0, 0, 3'd0, 3, "pulse_idle");
    tick(1);
    car_status = 4'b0000;
    tick(20);

    // Hazard raised during the 2nd ON cycle of LEFT preempts with a phase restart.
    reset_pulse(1);
    car_status = 4'b0001;
    expect_n(0, 0, 3'd0, 2, "hz_latency");
    expect_n(1, 0, 3'd1, 4, "hz_left_on");
    expect_n(1, 1, 3'd3, 4, "hz_restart_on");
    expect_n(0, 0, 3'd3, 4, "hz_off");
    tick(4);
    car_status = 4'b0101;
    tick(10);
    // Hazard dropped: finishes the current ON+OFF, then idles.
    car_status = 4'b0000;
    expect_n(1, 1, 3'd3, 4, "hz_drop_on");
    expect_n(0, 0, 3'd3, 4, "hz_drop_off");
    expect_n(0, 0, 3'd0, 2, "hz_drop_idle");
    tick(10);

    // Brake with right: left lamp steady on, right blinks; brake alone holds both on in IDLE.
    reset_pulse(1);
    car_status = 4'b1010;
    expect_n(0, 0, 3'd0, 2, "brk_latency");
    expect_n(1, 1, 3'd2, 4, "brk_right_on1");
    expect_n(1, 0, 3'd2, 4, "brk_right_off1");
    expect_n(1, 1, 3'd2, 4, "brk_right_on2");
    tick(14);
    car_status = 4'b1000;
    expect_n(1, 0, 3'd2, 4, "brk_right_off2");
    expect_n(1, 1, 3'd0, 3, "brk_idle");
    tick(7);

    // Opposite side requested after one flash: LEFT completes its minimum, then RIGHT with no gap.
    reset_pulse(1);
    car_status = 4'b0001;
    expect_n(0, 0, 3'd0, 2, "sw_latency");
    expect_n(1, 0, 3'd1, 4, "sw_left_on1");
    expect_n(0, 0, 3'd1, 4, "sw_left_off1");
    expect_n(1, 0, 3'd1, 4, "sw_left_on2");
    expect_n(0, 0, 3'd1, 4, "sw_left_off2");
    expect_n(0, 1, 3'd2, 4, "sw_right_on");
    expect_n(0, 0, 3'd2, 4, "sw_right_off");
    tick(11);
    car_status = 4'b0010;
    tick(15);

    // Left and right together rank as hazard.
    reset_pulse(1);
    car_status = 4'b0011;
    expect_n(0, 0, 3'd0, 2, "lr_latency");
    expect_n(1, 1, 3'd3, 2, "lr_hazard");
    tick(4);

    // Reset during a HAZARD ON phase clears everything on the next edge.
    reset_pulse(1);
    car_status = 4'b0100;
    expect_n(0, 0, 3'd0, 2, "rst_hz_latency");
    expect_n(1, 1, 3'd3, 2, "rst_hz_on");
    tick(4);
    rst = 1'b1;
    expect_n(0, 0, 3'd0, 1, "rst_mid_hazard");
    tick(1);
    car_status = 4'b0000;
    expect_n(0, 0, 3'd0, 2, "rst_hold");
    tick(2);
    rst = 1'b0;
    expect_n(0, 0, 3'd0, 3, "idle_after_rst");
    tick(3);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no completion by time %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
